fir_decim_fifo: RTL

- Downstream stage of the 16-tap synchronous FIR.
- Consumes the FIR's 11-bit signed output stream.
- Decimates it by DECIM and keeps the first sample of each group.
- Buffers kept samples in a small show-ahead FIFO, drained through a valid/ready handshake to the next consumer (DAC packer / capture logic).

---
 rtl/fir_decim_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: decimates the FIR output stream by DECIM, keeping the first
// sample of each group, and buffers kept samples in a show-ahead FIFO that is
// drained through a valid/ready handshake.
// Optional build macro FIR_DECIM_DROP_CNT_EN adds an 8-bit saturating drop counter.
module fir_decim_fifo #(
    parameter int unsigned DW    = 11,
    parameter int unsigned DECIM = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              din,
    input  logic                       din_valid,
    output logic [DW-1:0]              dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
`ifdef FIR_DECIM_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    input  logic                       clr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Keep the phase counter at least one bit wide so DECIM=1 stays legal.
    localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] phase_q;
    logic          overflow_q;
    logic          keep, push, pop, drop, full, empty;

    // Handshake and decimation decode.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        pop   = !empty && dout_ready;
        keep  = din_valid && (phase_q == '0);
        push  = keep && (!full || pop);
        drop  = keep && full && !pop;
    end

    // Decimation grid: advances only on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (din_valid) begin
            if (phase_q == PW'(DECIM - 1)) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PW'(1);
            end
        end
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef FIR_DECIM_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Saturating drop counter; clear restarts at 1 if a drop coincides.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (clr_ovf) begin
            drop_cnt_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign dout       = empty ? '0 : mem[rd_ptr_q];
    assign dout_valid = !empty;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule
